// File: rtl/draw_datapath_if.sv
// Command/pixel bundle between the game controller, draw_datapath and the frame-buffer writer.
interface draw_datapath_if;
  logic [3:0] state_in;
  logic       sel;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       flag;
  logic       collision;

  modport master (
    output state_in, sel,
    input  x, y, colour, plot, flag, collision
  );

  modport slave (
    input  state_in, sel,
    output x, y, colour, plot, flag, collision
  );
endinterface

// File: rtl/draw_datapath.sv
// Demuxes bird/wall command codes and sweeps their pixels into the frame buffer.
// Define COLLISION_DETECT_EN to build the sticky bird/wall/floor collision detector.
module draw_datapath #(
  parameter int unsigned BIRD_X    = 20,
  parameter int unsigned BIRD_SIZE = 4,
  parameter int unsigned WALL_W    = 4,
  parameter int unsigned GAP_Y     = 40,
  parameter int unsigned GAP_H     = 32,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120,
  parameter logic [2:0]  BIRD_COL  = 3'b110,
  parameter logic [2:0]  WALL_COL  = 3'b010
) (
  input  logic           clk,
  input  logic           reset,
  draw_datapath_if.slave bus
);
  localparam logic [3:0] C_DRAW  = 4'h1;
  localparam logic [3:0] C_ERASE = 4'h2;
  localparam logic [3:0] C_STEP  = 4'h3;
  localparam logic [3:0] C_FLAP  = 4'h4;

  localparam logic [6:0] BIRD_Y_MAX = 7'(SCR_H - BIRD_SIZE);
  localparam logic [6:0] BIRD_Y_RST = 7'((SCR_H - BIRD_SIZE) / 2);
  localparam logic [7:0] WALL_X_MAX = 8'(SCR_W - WALL_W);

  typedef enum logic [1:0] {S_IDLE, S_BIRD, S_WALL, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] bird_cmd_q, bird_cmd_d, wall_cmd_q, wall_cmd_d;
  logic [3:0] op_q, op_d;
  logic       bird_pend_q, bird_pend_d, wall_pend_q, wall_pend_d;
  logic       bird_clr, wall_clr;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [6:0] bird_y_q, bird_y_d;
  logic [7:0] wall_x_q, wall_x_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, flag_q, flag_d;
  logic       bird_ok, wall_ok, bird_last, wall_last, in_gap;

  // A code is pending only when it differs from the last one seen on its channel.
  always_comb begin
    bird_cmd_d  = bird_cmd_q;
    wall_cmd_d  = wall_cmd_q;
    bird_pend_d = bird_pend_q & ~bird_clr;
    wall_pend_d = wall_pend_q & ~wall_clr;
    if (!bus.sel) begin
      bird_cmd_d = bus.state_in;
      if (bus.state_in != bird_cmd_q) bird_pend_d = 1'b1;
    end else begin
      wall_cmd_d = bus.state_in;
      if (bus.state_in != wall_cmd_q) wall_pend_d = 1'b1;
    end
  end

  assign bird_ok   = bird_cmd_q inside {C_DRAW, C_ERASE, C_STEP, C_FLAP};
  assign wall_ok   = wall_cmd_q inside {C_DRAW, C_ERASE, C_STEP};
  assign bird_last = (col_q == 8'(BIRD_SIZE - 1)) && (row_q == 7'(BIRD_SIZE - 1));
  assign wall_last = (col_q == 8'(WALL_W - 1)) && (row_q == 7'(SCR_H - 1));
  assign in_gap    = (row_q >= 7'(GAP_Y)) && (row_q < 7'(GAP_Y + GAP_H));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    bird_clr = 1'b0;
    wall_clr = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    bird_y_d = bird_y_q;
    wall_x_d = wall_x_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    flag_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Unknown codes are consumed here without ever entering an op.
        if (bird_pend_q) begin
          bird_clr = 1'b1;
          op_d     = bird_cmd_q;
          if (bird_ok) state_d = S_BIRD;
        end else if (wall_pend_q) begin
          wall_clr = 1'b1;
          op_d     = wall_cmd_q;
          if (wall_ok) state_d = S_WALL;
        end
      end
      S_BIRD: begin
        if (op_q == C_STEP) begin
          bird_y_d = (bird_y_q >= BIRD_Y_MAX) ? BIRD_Y_MAX : bird_y_q + 7'd1;
          state_d  = S_DONE;
        end else if (op_q == C_FLAP) begin
          bird_y_d = (bird_y_q >= 7'd8) ? bird_y_q - 7'd8 : 7'd0;
          state_d  = S_DONE;
        end else begin
          plot_d   = 1'b1;
          x_d      = 8'(BIRD_X) + col_q;
          y_d      = bird_y_q + row_q;
          colour_d = (op_q == C_DRAW) ? BIRD_COL : 3'b000;
          if (col_q == 8'(BIRD_SIZE - 1)) begin
            col_d = 8'd0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (bird_last) begin
            col_d   = 8'd0;
            row_d   = 7'd0;
            state_d = S_DONE;
          end
        end
      end
      S_WALL: begin
        if (op_q == C_STEP) begin
          wall_x_d = (wall_x_q == 8'd0) ? WALL_X_MAX : wall_x_q - 8'd1;
          state_d  = S_DONE;
        end else begin
          // Gap rows still cost a cycle so the sweep length is fixed.
          plot_d   = ~in_gap;
          x_d      = wall_x_q + col_q;
          y_d      = row_q;
          colour_d = (op_q == C_DRAW) ? WALL_COL : 3'b000;
          if (row_q == 7'(SCR_H - 1)) begin
            row_d = 7'd0;
            col_d = col_q + 8'd1;
          end else begin
            row_d = row_q + 7'd1;
          end
          if (wall_last) begin
            col_d   = 8'd0;
            row_d   = 7'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        flag_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bird_cmd_q  <= 4'h0;
      wall_cmd_q  <= 4'h0;
      bird_pend_q <= 1'b0;
      wall_pend_q <= 1'b0;
      op_q        <= 4'h0;
      col_q       <= 8'd0;
      row_q       <= 7'd0;
      bird_y_q    <= BIRD_Y_RST;
      wall_x_q    <= WALL_X_MAX;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'b000;
      plot_q      <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bird_cmd_q  <= bird_cmd_d;
      wall_cmd_q  <= wall_cmd_d;
      bird_pend_q <= bird_pend_d;
      wall_pend_q <= wall_pend_d;
      op_q        <= op_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bird_y_q    <= bird_y_d;
      wall_x_q    <= wall_x_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      flag_q      <= flag_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.flag   = flag_q;

`ifdef COLLISION_DETECT_EN
  logic coll_q, moved, overlap, outside_gap, floor_hit;

  // Judged on the post-move position so the flag lands the cycle after the move.
  assign moved       = ((state_q == S_BIRD) && ((op_q == C_STEP) || (op_q == C_FLAP))) ||
                       ((state_q == S_WALL) && (op_q == C_STEP));
  assign overlap     = ({1'b0, wall_x_d} <= 9'(BIRD_X + BIRD_SIZE - 1)) &&
                       ({1'b0, wall_x_d} + 9'(WALL_W - 1) >= 9'(BIRD_X));
  assign outside_gap = (bird_y_d < 7'(GAP_Y)) ||
                       ({1'b0, bird_y_d} + 8'(BIRD_SIZE - 1) > 8'(GAP_Y + GAP_H - 1));
  assign floor_hit   = (bird_y_d == BIRD_Y_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                coll_q <= 1'b0;
    else if (moved && ((overlap && outside_gap) || floor_hit)) coll_q <= 1'b1;
  end

  assign bus.collision = coll_q;
`else
  assign bus.collision = 1'b0;
`endif
endmodule

// File: doc/draw_datapath.md
DRAW_DATAPATH -- requirements
Module: draw_datapath

Interface
REQ-001 Parameters SHALL be: BIRD_X, 20, fixed bird column; BIRD_SIZE, 4, bird square edge in pixels; WALL_W, 4, wall width; GAP_Y, 40, top row of wall gap; GAP_H, 32, gap height; SCR_W, 160, screen width; SCR_H, 120, screen height; BIRD_COL, 3'b110, bird colour; WALL_COL, 3'b010, wall colour.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 state_in  input  4  time-multiplexed state code from the game controller.
REQ-005 sel  input  1  channel of state_in this cycle: 0 = bird, 1 = wall.
REQ-006 x  output  8  pixel column to plot.
REQ-007 y  output  7  pixel row to plot.
REQ-008 colour  output  3  pixel colour.
REQ-009 plot  output  1  pixel write strobe, one pixel per high cycle.
REQ-010 flag  output  1  one-cycle pulse, command completed.
REQ-011 collision  output  1  sticky bird/wall or bird/floor hit.

Function
REQ-012 Demux: each cycle state_in SHALL be latched into bird_cmd when sel=0, wall_cmd when sel=1.
REQ-013 A channel SHALL raise its pending bit when its newly latched code differs from its previous latched code; pending depth is one, and a newer code overwrites an unserved one.
REQ-014 Codes: 4'h1 DRAW, 4'h2 ERASE, 4'h3 STEP, 4'h4 FLAP (bird only); all other codes, and FLAP on wall, SHALL clear pending with no plot and no flag.
REQ-015 FSM states SHALL be IDLE, BIRD_OP, WALL_OP, DONE; IDLE->BIRD_OP if bird pending, else IDLE->WALL_OP if wall pending; bird wins when both are pending.
REQ-016 On entering an op, the channel's pending bit SHALL clear and its code SHALL be captured; later state_in changes do not affect the op in progress.
REQ-017 DRAW/ERASE on bird: BIRD_SIZE*BIRD_SIZE cycles, row-major sweep from (BIRD_X, bird_y), plot=1 every cycle, colour BIRD_COL (DRAW) or 0 (ERASE).
REQ-018 DRAW/ERASE on wall: WALL_W*SCR_H cycles, column-major from (wall_x, 0); plot=0 on rows GAP_Y..GAP_Y+GAP_H-1, else plot=1; colour WALL_COL or 0.
REQ-019 STEP on bird: bird_y += 1, saturating at SCR_H-BIRD_SIZE; FLAP: bird_y -= 8, saturating at 0; both take one cycle.
REQ-020 STEP on wall: wall_x -= 1; from 0 it SHALL wrap to SCR_W-WALL_W; one cycle.
REQ-021 After the op's last cycle, the FSM SHALL enter DONE for one cycle with flag=1, then return to IDLE; plot=0 in IDLE and DONE.
REQ-022 Latency from pending set to first plot SHALL be at most 2 cycles when the FSM is IDLE.
REQ-023 x, y and colour SHALL be registered and aligned with plot.

Reset
REQ-024 Reset SHALL force: FSM IDLE, both pending 0, bird_cmd/wall_cmd 0, bird_y = (SCR_H-BIRD_SIZE)/2, wall_x = SCR_W-WALL_W, x=0, y=0, colour=0, plot=0, flag=0, collision=0.
REQ-025 Reset asserted mid-op SHALL abort the sweep immediately, with no flag pulse.

Configuration
REQ-026 With COLLISION_DETECT_EN defined, collision SHALL set on the cycle after any STEP/FLAP that leaves the bird overlapping columns wall_x..wall_x+WALL_W-1 outside the gap rows, or bird_y = SCR_H-BIRD_SIZE; it stays set until reset.
REQ-027 Without COLLISION_DETECT_EN, collision SHALL be constant 0 and no comparison logic SHALL be built.

Verification
REQ-028 After reset, sel toggling, bird code 0->1 -> 16 plot cycles, x 20..23, y 58..61, colour 3'b110, then flag for 1 cycle.
REQ-029 Bird and wall both change to 1 in the same sel pair -> bird sweep of 16 cycles, flag, then wall sweep of 480 cycles with 128 plot=0 gap cycles, flag.
REQ-030 Wall STEP 156 times from reset -> wall_x=0; one more STEP -> wall_x=156.
REQ-031 Bird FLAP 10 times from reset -> bird_y=0, no underflow; STEP up to 116 -> saturates at 116, collision=1 (macro defined), 0 (undefined).
REQ-032 Reset asserted at pixel 7 of a bird DRAW -> plot=0 next cycle, no flag, all outputs at REQ-024 values.
